// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller for the 8-bit accumulator CPU.
//
// Fetches an instruction byte over a req/ack handshake into IR, executes it in
// one cycle by steering the external combinational ALU and accumulator, and
// publishes accumulator values on a valid/ready output port.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   start                  begin fetching at PC=0 from IDLE or HALT
//   step                   single-step request (only with CPU_SEQ_STEP_EN)
//   imem_req/addr/ack/data instruction fetch handshake
//   alu_sel/a/b, alu_result ALU control, operands and result
//   acc_rdata, acc_we, acc_wdata accumulator read/write
//   out_valid/data/ready   output port handshake
//   halted, pc             status
//
// Optional feature: define CPU_SEQ_STEP_EN to add the step input. The
// sequencer then parks in FETCH with imem_req low until step is seen, runs one
// instruction and parks again.
module cpu_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CPU_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] acc_rdata,
  output logic              acc_we,
  output logic [DATA_W-1:0] acc_wdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StOutw, StHalt} state_e;

`ifdef CPU_SEQ_STEP_EN
  // Entering FETCH parks with the request low until a step arrives.
  localparam logic FetchReq = 1'b0;
`else
  localparam logic FetchReq = 1'b1;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              req_q, req_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_target;
  logic [DATA_W-1:0] imm_data;

  assign opcode     = ir_q[7:4];
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign jmp_target = ADDR_W'(ir_q[3:0]);
  assign imm_data   = DATA_W'(ir_q[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      req_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    req_d       = req_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_we      = 1'b0;
    acc_wdata   = '0;
    alu_sel     = 4'h0;
    alu_a       = '0;
    alu_b       = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          req_d   = FetchReq;
        end
      end

      StFetch: begin
`ifdef CPU_SEQ_STEP_EN
        if (!req_q && step) req_d = 1'b1;
`endif
        // Only an ack against an outstanding request loads IR.
        if (req_q && imem_ack) begin
          ir_d    = imem_data;
          req_d   = 1'b0;
          state_d = StExec;
        end
      end

      StExec: begin
        alu_sel = opcode;
        alu_a   = acc_rdata;
        alu_b   = imm_data;
        state_d = StFetch;
        req_d   = FetchReq;
        pc_d    = pc_inc;
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
            acc_we    = 1'b1;
            acc_wdata = alu_result;
          end
          4'h5: begin
            acc_we    = 1'b1;
            acc_wdata = imm_data;
          end
          4'h6: pc_d = jmp_target;
          4'h7: pc_d = (acc_rdata == '0) ? jmp_target : pc_inc;
          4'h8: begin
            out_data_d  = acc_rdata;
            out_valid_d = 1'b1;
            state_d     = StOutw;
            req_d       = 1'b0;
            pc_d        = pc_q;
          end
          4'hf: begin
            state_d = StHalt;
            req_d   = 1'b0;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end

      StOutw: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = StFetch;
          req_d       = FetchReq;
        end
      end

      StHalt: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
          req_d   = FetchReq;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = (state_q == StHalt);
  assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: models the instruction memory,
// accumulator and ALU around the DUT and checks hand-computed expectations.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       step = 1'b1;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [7:0] acc_rdata;
  logic       acc_we;
  logic [7:0] acc_wdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       halted;
  logic [3:0] pc;

  logic [7:0] prog [16];
  logic       use_prog = 1'b1;
  logic       auto_ack = 1'b1;
  logic       force_ack = 1'b0;
  logic [7:0] manual_data = 8'h00;
  logic [7:0] acc;

  int checks = 0;
  int errors = 0;

  // Monitors
  int         n_xfer = 0;
  int         we_cycles = 0;
  int         we_rises = 0;
  logic       we_prev = 1'b0;
  logic [7:0] last_out = 8'h00;
  logic [3:0] fetch_log [$];

  always #5 clk = ~clk;

  assign imem_ack  = force_ack | (auto_ack & imem_req);
  assign imem_data = use_prog ? prog[imem_addr] : manual_data;
  assign acc_rdata = acc;

  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a * alu_b;
      4'h2: alu_result = alu_a & alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h4: alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (rst) acc <= 8'h00;
    else if (acc_we) acc <= acc_wdata;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_xfer   <= n_xfer + 1;
        last_out <= out_data;
      end
      if (acc_we) we_cycles <= we_cycles + 1;
      if (acc_we && !we_prev) we_rises <= we_rises + 1;
      if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
    end
    we_prev <= acc_we;
  end

  cpu_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef CPU_SEQ_STEP_EN
    .step      (step),
`endif
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .acc_rdata (acc_rdata),
    .acc_we    (acc_we),
    .acc_wdata (acc_wdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .pc        (pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h90;
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 100 && !halted; i++) tick();
    check(tag, 32'(halted), 32'd1);
  endtask

  int xfer0, wec0, wer0, flog0;

  initial begin
    clear_prog();
    tick();
    do_reset();
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_acc_we", 32'(acc_we), 32'd0);

    // 1: LDI 3, ADD 4, OUT, HALT
    prog[0] = 8'h53; prog[1] = 8'h04; prog[2] = 8'h80; prog[3] = 8'hF0;
    xfer0 = n_xfer;
    start = 1'b1; tick(); start = 1'b0;
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", 32'(imem_addr), 32'd0);
    run_to_halt("t1_halt_timeout");
    check("t1_xfers", 32'(n_xfer - xfer0), 32'd1);
    check("t1_out_data", 32'(last_out), 32'h07);
    check("t1_pc", 32'(pc), 32'd3);
    tick();
    check("t1_pc_frozen", 32'(pc), 32'd3);
    start = 1'b1; tick(); start = 1'b0;
    check("t1_restart_halted", 32'(halted), 32'd0);
    check("t1_restart_pc", 32'(pc), 32'd0);
    check("t1_restart_req", 32'(imem_req), 32'd1);

    // 2: LDI 2, MUL 3, OUT, HALT
    do_reset();
    prog[0] = 8'h52; prog[1] = 8'h13; prog[2] = 8'h80; prog[3] = 8'hF0;
    xfer0 = n_xfer; wec0 = we_cycles; wer0 = we_rises;
    start = 1'b1; tick(); start = 1'b0;
    run_to_halt("t2_halt_timeout");
    check("t2_out_data", 32'(last_out), 32'h06);
    check("t2_xfers", 32'(n_xfer - xfer0), 32'd1);
    check("t2_we_cycles", 32'(we_cycles - wec0), 32'd2);
    check("t2_we_pulses", 32'(we_rises - wer0), 32'd2);

    // 3: JZ taken, JZ not taken, JMP 15, NOP at 15 wraps to 0
    do_reset();
    clear_prog();
    prog[0] = 8'h50; prog[1] = 8'h75; prog[5] = 8'h51; prog[6] = 8'h72; prog[7] = 8'h6F;
    flog0 = fetch_log.size();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 60 && fetch_log.size() < flog0 + 7; i++) tick();
    check("t3_fetch_count", 32'(fetch_log.size() >= flog0 + 7), 32'd1);
    if (fetch_log.size() >= flog0 + 7) begin
      check("t3_jz_taken", 32'(fetch_log[flog0 + 2]), 32'd5);
      check("t3_jz_not_taken", 32'(fetch_log[flog0 + 4]), 32'd7);
      check("t3_jmp15", 32'(fetch_log[flog0 + 5]), 32'd15);
      check("t3_wrap", 32'(fetch_log[flog0 + 6]), 32'd0);
    end

    // 4: delayed ack, spurious ack in EXEC
    do_reset();
    use_prog = 1'b0; auto_ack = 1'b0; out_ready = 1'b0;
    manual_data = 8'h5A;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_req_held", 32'(imem_req), 32'd1);
      check("t4_addr_stable", 32'(imem_addr), 32'd0);
      check("t4_no_we", 32'(acc_we), 32'd0);
      tick();
    end
    manual_data = 8'h55; force_ack = 1'b1;
    tick();
    manual_data = 8'h6F;
    check("t4_exec_we", 32'(acc_we), 32'd1);
    check("t4_exec_wdata", 32'(acc_wdata), 32'h05);
    check("t4_req_low_exec", 32'(imem_req), 32'd0);
    tick();
    force_ack = 1'b0;
    check("t4_pc_after_ldi", 32'(pc), 32'd1);
    check("t4_req_fetch", 32'(imem_req), 32'd1);
    tick();
    check("t4_wait_no_ack", 32'(imem_req), 32'd1);
    manual_data = 8'h80; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("t4_out_exec_we", 32'(acc_we), 32'd0);
    tick();

    // 5: out_ready low for 4 cycles
    for (int i = 0; i < 4; i++) begin
      check("t5_valid_held", 32'(out_valid), 32'd1);
      check("t5_data_held", 32'(out_data), 32'h05);
      check("t5_pc_held", 32'(pc), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_valid_drop", 32'(out_valid), 32'd0);
    check("t5_pc_adv", 32'(pc), 32'd2);
    check("t5_req", 32'(imem_req), 32'd1);

    // 6: reset during FETCH, then during OUTW
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6f_pc", 32'(pc), 32'd0);
    check("t6f_req", 32'(imem_req), 32'd0);
    check("t6f_valid", 32'(out_valid), 32'd0);
    check("t6f_halted", 32'(halted), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_restart_addr", 32'(imem_addr), 32'd0);
    manual_data = 8'h80; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check("t6_in_outw", 32'(out_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6o_valid", 32'(out_valid), 32'd0);
    check("t6o_pc", 32'(pc), 32'd0);
    check("t6o_req", 32'(imem_req), 32'd0);
    tick();
    check("t6_idle_quiet", 32'(imem_req), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_restart_req", 32'(imem_req), 32'd1);
    check("t6_restart_addr2", 32'(imem_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
